// File: rtl/can_lbs_arb.sv
// rtl/can_lbs_arb.sv - host/brake local-bus arbiter in front of the brake CAN register port
// Optional starvation monitor: define CAN_ARB_STARVE_EN.
module can_lbs_arb #(
    parameter int HOST_GUARD = 8,
    parameter int RD_LAT     = 2,
    parameter int STARVE_CYC = 4096,
    parameter int U_DLY      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_cs_n,
    input  logic       h_we,
    input  logic       h_re,
    input  logic [7:0] h_addr,
    input  logic [7:0] h_din,
    output logic [7:0] h_dout,
    input  logic       brk_req,
    input  logic       brk_wr,
    input  logic [7:0] brk_addr,
    input  logic [7:0] brk_wdata,
    output logic       brk_ack,
    output logic [7:0] brk_rdata,
    input  logic       brk_clr,
    output logic       brk_starve,
    output logic       s_cs_n,
    output logic       s_we,
    output logic       s_re,
    output logic [7:0] s_addr,
    output logic [7:0] s_din,
    input  logic [7:0] s_rd_dat
);

    localparam int GW = $clog2(HOST_GUARD + 1);
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RDW, S_DONE} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] guard;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic          lat_wr;
    logic [7:0]    lat_addr, lat_wdata;
    logic          load, cap;
    logic          host_act, host_stb, brk_go;
    logic          unused_cfg;

    assign unused_cfg = (U_DLY != 0);

    assign host_act = ~h_cs_n;
    assign host_stb = host_act & (h_we | h_re);
    // The guard also holds off a brake strobe already parked in ACC.
    assign brk_go   = (state == S_ACC) && !host_act && (guard == '0);
    assign brk_ack  = (state == S_DONE);
    assign h_dout   = s_rd_dat;

    always_comb begin
        s_cs_n = 1'b1;
        s_we   = 1'b0;
        s_re   = 1'b0;
        s_addr = lat_addr;
        s_din  = lat_wdata;
        if (host_act) begin
            s_cs_n = 1'b0;
            s_we   = h_we;
            s_re   = h_re;
            s_addr = h_addr;
            s_din  = h_din;
        end else if (brk_go) begin
            s_cs_n = 1'b0;
            s_we   = lat_wr;
            s_re   = ~lat_wr;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        load     = 1'b0;
        cap      = 1'b0;
        case (state)
            S_IDLE: begin
                if (brk_req && !host_act && (guard == '0)) begin
                    state_nx = S_ACC;
                    load     = 1'b1;
                end
            end
            S_ACC: begin
                if (brk_go) begin
                    if (lat_wr) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_RDW;
                        wait_nx  = WW'(RD_LAT - 1);
                    end
                end
            end
            S_RDW: begin
                if (host_stb) begin
                    state_nx = S_IDLE;
                end else if (wait_cnt == '0) begin
                    cap      = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    wait_nx = wait_cnt - 1'b1;
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard     <= '0;
            wait_cnt  <= '0;
            lat_wr    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 8'h00;
            brk_rdata <= 8'h00;
        end else begin
            if (host_stb) begin
                guard <= GW'(HOST_GUARD);
            end else if (guard != '0) begin
                guard <= guard - 1'b1;
            end
            wait_cnt <= wait_nx;
            if (load) begin
                lat_wr    <= brk_wr;
                lat_addr  <= brk_addr;
                lat_wdata <= brk_wdata;
            end
            if (cap) begin
                brk_rdata <= s_rd_dat;
            end
        end
    end

`ifdef CAN_ARB_STARVE_EN
    localparam logic [12:0] STARVE_TH = 13'(STARVE_CYC);
    logic [12:0] starve_cnt;

    // Set fires once when the counter passes the threshold, so a clear sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 13'd0;
            brk_starve <= 1'b0;
        end else begin
            if (brk_ack) begin
                starve_cnt <= 13'd0;
            end else if (brk_req && (starve_cnt != 13'h1FFF)) begin
                starve_cnt <= starve_cnt + 13'd1;
            end
            if (starve_cnt == STARVE_TH) begin
                brk_starve <= 1'b1;
            end else if (brk_clr) begin
                brk_starve <= 1'b0;
            end
        end
    end
`else
    logic unused_starve;
    assign unused_starve = brk_clr ^ (STARVE_CYC != 0);
    assign brk_starve    = 1'b0;
`endif

endmodule

// File: tb/tb_can_lbs_arb.sv
// tb/tb_can_lbs_arb.sv - self-checking bench for can_lbs_arb
module tb_can_lbs_arb;

    localparam int HG = 8;
    localparam int RL = 2;
    localparam int SC = 4096;
`ifdef CAN_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       h_cs_n = 1'b1, h_we = 1'b0, h_re = 1'b0;
    logic [7:0] h_addr = 8'h00, h_din = 8'h00, h_dout;
    logic       brk_req = 1'b0, brk_wr = 1'b0, brk_clr = 1'b0;
    logic [7:0] brk_addr = 8'h00, brk_wdata = 8'h00, brk_rdata;
    logic       brk_ack, brk_starve;
    logic       s_cs_n, s_we, s_re;
    logic [7:0] s_addr, s_din;
    logic [7:0] s_rd_dat = 8'h00;

    logic [7:0] rd_tab [256];
    int n_checks = 0;
    int n_fail   = 0;

    logic       o_cs_n, o_we, o_re, o_ack, o_starve;
    logic [7:0] o_addr, o_din, o_rdata, o_dout;

    can_lbs_arb #(.HOST_GUARD(HG), .RD_LAT(RL), .STARVE_CYC(SC), .U_DLY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_cs_n(h_cs_n), .h_we(h_we), .h_re(h_re), .h_addr(h_addr), .h_din(h_din), .h_dout(h_dout),
        .brk_req(brk_req), .brk_wr(brk_wr), .brk_addr(brk_addr), .brk_wdata(brk_wdata),
        .brk_ack(brk_ack), .brk_rdata(brk_rdata), .brk_clr(brk_clr), .brk_starve(brk_starve),
        .s_cs_n(s_cs_n), .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_din(s_din), .s_rd_dat(s_rd_dat)
    );

    always #5 clk = ~clk;

    // Slave: read data appears the cycle after a read strobe and holds.
    always @(posedge clk) begin
        if (!s_cs_n && s_re) s_rd_dat <= rd_tab[s_addr];
    end

    task automatic obs();
        @(negedge clk);
        o_cs_n = s_cs_n; o_we = s_we; o_re = s_re; o_addr = s_addr; o_din = s_din;
        o_ack = brk_ack; o_rdata = brk_rdata; o_dout = h_dout; o_starve = brk_starve;
        @(posedge clk); #1;
    endtask

    task automatic host_idle();
        h_cs_n = 1'b1; h_we = 1'b0; h_re = 1'b0;
    endtask

    task automatic idle(input int n);
        host_idle(); brk_req = 1'b0; brk_clr = 1'b0;
        repeat (n) obs();
    endtask

    task automatic test_reset();
        host_idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        obs();
        n_checks++;
        if ({o_cs_n, o_we, o_re} !== 3'b100) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 100", {o_cs_n, o_we, o_re});
        end
        n_checks++;
        if ({o_addr, o_din} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_addr_din: got %h expected 0000", {o_addr, o_din});
        end
        n_checks++;
        if ({o_ack, o_rdata, o_starve} !== 10'd0) begin
            n_fail++; $display("FAIL reset_brk: got ack=%b rdata=%h starve=%b expected 0", o_ack, o_rdata, o_starve);
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_brake_single(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int stb_at = -1, ack_at = -1, nstb = 0;
        logic [7:0] rd_seen = 8'h00;
        brk_req = 1'b1; brk_wr = wr; brk_addr = a; brk_wdata = d;
        for (int k = 0; k < 20; k++) begin
            obs();
            if (!o_cs_n) begin
                nstb++;
                if (stb_at < 0) stb_at = k;
                n_checks++;
                if ({o_we, o_re, o_addr} !== {wr, ~wr, a} || (wr && o_din !== d)) begin
                    n_fail++;
                    $display("FAIL single_fields: got we=%b re=%b addr=%h din=%h expected we=%b addr=%h din=%h",
                             o_we, o_re, o_addr, o_din, wr, a, d);
                end
            end
            if (o_ack && ack_at < 0) begin
                ack_at = k; rd_seen = o_rdata; brk_req = 1'b0;
            end
        end
        n_checks++;
        if (stb_at != 1 || nstb != 1) begin
            n_fail++; $display("FAIL single_strobe: got at=%0d count=%0d expected at=1 count=1", stb_at, nstb);
        end
        n_checks++;
        if (ack_at != (wr ? 2 : 2 + RL)) begin
            n_fail++; $display("FAIL single_ack_lat: got %0d expected %0d", ack_at, wr ? 2 : 2 + RL);
        end
        if (!wr) begin
            n_checks++;
            if (rd_seen !== rd_tab[a]) begin
                n_fail++; $display("FAIL single_rdata: got %h expected %h", rd_seen, rd_tab[a]);
            end
        end
        idle(3);
    endtask

    task automatic test_host_pass();
        logic [7:0] exp_dout = s_rd_dat;
        logic [1:0] op;
        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom_range(0, 3));
            h_cs_n = 1'b0; h_we = op[0]; h_re = op[1];
            h_addr = 8'($urandom); h_din = 8'($urandom);
            obs();
            n_checks++;
            if ({o_cs_n, o_we, o_re, o_addr, o_din} !== {1'b0, h_we, h_re, h_addr, h_din}) begin
                n_fail++;
                $display("FAIL host_pass: got cs_n=%b we=%b re=%b addr=%h din=%h expected 0 %b %b %h %h",
                         o_cs_n, o_we, o_re, o_addr, o_din, h_we, h_re, h_addr, h_din);
            end
            n_checks++;
            if (o_dout !== exp_dout) begin
                n_fail++; $display("FAIL host_dout: got %h expected %h", o_dout, exp_dout);
            end
            if (h_re) exp_dout = rd_tab[h_addr];
        end
        idle(HG + 2);
    endtask

    task automatic test_host_contention(input logic [7:0] a, input logic [7:0] d);
        int stb_at = -1, ack_at = -1, nstb = 0;
        logic [7:0] ha = 8'($urandom);
        brk_req = 1'b1; brk_wr = 1'b1; brk_addr = a; brk_wdata = d;
        for (int k = 0; k < 30; k++) begin
            h_cs_n = (k != 1); h_we = (k == 1); h_addr = ha; h_din = ~d;
            obs();
            if (k == 1) begin
                n_checks++;
                if ({o_cs_n, o_we, o_re, o_addr, o_din} !== {3'b010, ha, ~d}) begin
                    n_fail++; $display("FAIL contend_host: got cs_n=%b addr=%h din=%h expected 0 %h %h",
                                       o_cs_n, o_addr, o_din, ha, ~d);
                end
            end else if (!o_cs_n) begin
                nstb++;
                if (stb_at < 0) stb_at = k;
            end
            if (o_ack && ack_at < 0) begin ack_at = k; brk_req = 1'b0; end
        end
        // Host strobe in cycle 1; guard empties HG+1 cycles later.
        n_checks++;
        if (stb_at != 1 + HG + 1 || nstb != 1) begin
            n_fail++; $display("FAIL contend_strobe: got at=%0d count=%0d expected at=%0d count=1", stb_at, nstb, HG + 2);
        end
        n_checks++;
        if (ack_at != HG + 3) begin
            n_fail++; $display("FAIL contend_ack: got %0d expected %0d", ack_at, HG + 3);
        end
        idle(3);
    endtask

    task automatic test_rdw_abort(input logic [7:0] a);
        int ack_at = -1, nack = 0, nstb = 0;
        logic [7:0] ha = a ^ 8'h81;
        logic [7:0] rd_seen = 8'h00;
        brk_req = 1'b1; brk_wr = 1'b0; brk_addr = a;
        for (int k = 0; k < 40; k++) begin
            h_cs_n = (k != 2); h_re = (k == 2); h_addr = ha;
            obs();
            if (k != 2 && !o_cs_n) nstb++;
            if (k == 3) begin
                n_checks++;
                if (o_dout !== rd_tab[ha]) begin
                    n_fail++; $display("FAIL abort_hdout: got %h expected %h", o_dout, rd_tab[ha]);
                end
            end
            if (o_ack) begin
                nack++;
                if (ack_at < 0) begin ack_at = k; rd_seen = o_rdata; brk_req = 1'b0; end
            end
        end
        n_checks++;
        if (ack_at != 2 + HG + 2 + RL + 1 || nack != 1) begin
            n_fail++; $display("FAIL abort_ack: got at=%0d count=%0d expected at=%0d count=1", ack_at, nack, HG + RL + 5);
        end
        n_checks++;
        if (nstb != 2) begin
            n_fail++; $display("FAIL abort_strobes: got %0d expected 2", nstb);
        end
        n_checks++;
        if (rd_seen !== rd_tab[a]) begin
            n_fail++; $display("FAIL abort_rdata: got %h expected %h", rd_seen, rd_tab[a]);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic       op_wr [4];
        logic [7:0] op_a [4], op_d [4];
        int i = 0, exp_ack;
        for (int j = 0; j < 4; j++) begin
            op_wr[j] = 1'($urandom); op_a[j] = 8'($urandom); op_d[j] = 8'($urandom);
        end
        exp_ack = op_wr[0] ? 2 : 2 + RL;
        for (int k = 0; k < 60; k++) begin
            brk_req = (i < 4);
            if (i < 4) begin brk_wr = op_wr[i]; brk_addr = op_a[i]; brk_wdata = op_d[i]; end
            obs();
            if (!o_cs_n && i < 4) begin
                n_checks++;
                if ({o_we, o_addr} !== {op_wr[i], op_a[i]} || (op_wr[i] && o_din !== op_d[i])) begin
                    n_fail++; $display("FAIL b2b_fields op%0d: got we=%b addr=%h din=%h expected %b %h %h",
                                       i, o_we, o_addr, o_din, op_wr[i], op_a[i], op_d[i]);
                end
            end
            if (o_ack) begin
                n_checks++;
                if (i >= 4 || k != exp_ack || (!op_wr[i] && o_rdata !== rd_tab[op_a[i]])) begin
                    n_fail++; $display("FAIL b2b_ack op%0d: got cycle=%0d rdata=%h expected cycle=%0d", i, k, o_rdata, exp_ack);
                end
                i++;
                if (i < 4) exp_ack = exp_ack + 1 + (op_wr[i] ? 2 : 2 + RL);
            end
        end
        n_checks++;
        if (i != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 4", i);
        end
        idle(3);
    endtask

    task automatic test_random_traffic();
        int last_hs, last_bs, nack, nstb, burst;
        logic hs;
        for (int t = 0; t < 6; t++) begin
            last_hs = -100; last_bs = -100; nack = 0; nstb = 0;
            burst = $urandom_range(0, 12);
            brk_req = 1'b1; brk_wr = 1'($urandom); brk_addr = 8'($urandom); brk_wdata = 8'($urandom);
            for (int k = 0; k < 80; k++) begin
                hs = (k < burst) && ($urandom_range(0, 2) == 0);
                h_cs_n = ~hs; h_we = hs & (k[0]); h_re = hs & ~k[0];
                h_addr = 8'($urandom); h_din = 8'($urandom);
                obs();
                if (hs) begin
                    n_checks++;
                    if ({o_cs_n, o_we, o_re, o_addr} !== {1'b0, h_we, h_re, h_addr}) begin
                        n_fail++; $display("FAIL rnd_host t%0d k%0d: got addr=%h expected %h", t, k, o_addr, h_addr);
                    end
                    last_hs = k;
                end else if (!o_cs_n) begin
                    nstb++; last_bs = k;
                    n_checks++;
                    if (k - last_hs <= HG || o_addr !== brk_addr || o_we !== brk_wr) begin
                        n_fail++; $display("FAIL rnd_brake t%0d: got cycle=%0d addr=%h last_host=%0d expected addr=%h",
                                           t, k, o_addr, last_hs, brk_addr);
                    end
                end
                if (o_ack) begin
                    nack++;
                    n_checks++;
                    if (k != last_bs + (brk_wr ? 1 : RL + 1) || (!brk_wr && o_rdata !== rd_tab[brk_addr])) begin
                        n_fail++; $display("FAIL rnd_ack t%0d: got cycle=%0d rdata=%h expected cycle=%0d rdata=%h",
                                           t, k, o_rdata, last_bs + (brk_wr ? 1 : RL + 1), rd_tab[brk_addr]);
                    end
                    brk_req = 1'b0;
                end
            end
            n_checks++;
            if (nack != 1 || (brk_wr && nstb != 1)) begin
                n_fail++; $display("FAIL rnd_count t%0d: got acks=%0d strobes=%0d expected 1", t, nack, nstb);
            end
            idle(2);
        end
    endtask

    task automatic test_reset_mid(input logic [7:0] a, input logic [7:0] d);
        int stb_at = -1, ack_at = -1, nstb = 0, nack = 0;
        brk_req = 1'b1; brk_wr = 1'b1; brk_addr = a; brk_wdata = d;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) rst_n = 1'b0;
            if (k == 3) rst_n = 1'b1;
            obs();
            if (k == 1) begin
                n_checks++;
                if ({o_cs_n, o_we, o_re, o_ack} !== 4'b1000) begin
                    n_fail++; $display("FAIL rstmid_outputs: got cs_n=%b we=%b re=%b ack=%b expected 1000",
                                       o_cs_n, o_we, o_re, o_ack);
                end
            end
            if (!o_cs_n) begin nstb++; if (stb_at < 0) stb_at = k; end
            if (o_ack) begin nack++; if (ack_at < 0) begin ack_at = k; brk_req = 1'b0; end end
        end
        n_checks++;
        if (stb_at != 4 || nstb != 1 || ack_at != 5 || nack != 1) begin
            n_fail++; $display("FAIL rstmid_resume: got stb=%0d/%0d ack=%0d/%0d expected 4/1 5/1", stb_at, nstb, ack_at, nack);
        end
        idle(3);
    endtask

    task automatic test_starve();
        int early = 0, ack_at = -1;
        logic hs, done = 1'b0, exp;
        rst_n = 1'b0; obs(); rst_n = 1'b1;
        idle(2);
        brk_wr = 1'b1; brk_addr = 8'h11; brk_wdata = 8'h22;
        for (int k = 0; k < 5100; k++) begin
            hs = (k <= 5000) && (k % 4 == 0);
            h_cs_n = ~hs; h_we = hs; h_addr = 8'h40; h_din = k[7:0];
            brk_req = ~done;
            brk_clr = (k == SC) || (k == 5000);
            obs();
            if (o_ack) begin
                if (k <= 5000) early++;
                else if (ack_at < 0) ack_at = k;
                done = 1'b1;
            end
            if (k == SC || k == SC + 1 || k == 4500 || k == 5001 || k == 5099) begin
                exp = STARVE_ON && (k > SC) && (k <= 5000);
                n_checks++;
                if (o_starve !== exp) begin
                    n_fail++; $display("FAIL starve_flag k=%0d: got %b expected %b", k, o_starve, exp);
                end
            end
        end
        n_checks++;
        if (early != 0 || ack_at != 5000 + HG + 3) begin
            n_fail++; $display("FAIL starve_ack: got early=%0d at=%0d expected 0 and %0d", early, ack_at, 5000 + HG + 3);
        end
        brk_clr = 1'b0;
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rd_tab[i] = 8'($urandom);
        rd_tab[2] = 8'h3F;
        test_reset();
        test_brake_single(1'b1, 8'h0A, 8'h5C);
        test_brake_single(1'b0, 8'h02, 8'h00);
        for (int i = 0; i < 4; i++) test_brake_single(1'($urandom), 8'($urandom), 8'($urandom));
        test_host_pass();
        test_host_contention(8'($urandom), 8'($urandom));
        test_rdw_abort(8'($urandom));
        test_back_to_back();
        test_random_traffic();
        test_reset_mid(8'h33, 8'hC4);
        test_starve();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/can_lbs_arb.md
# can_lbs_arb

Two-master local-bus arbiter in front of the brake CAN channel's `can_top` register port. It merges DSP-side CAN bus cycles from `lbs_ctrl` (host) with register accesses from the brake heartbeat engine (brake master). Host cycles always pass through with zero added latency. Brake accesses are slotted into host-idle gaps under a request/acknowledge handshake, which makes the brake channel safely shareable.

## Interface
- `HOST_GUARD`, 8: cycles after any host strobe during which brake accesses are blocked, so host read data stays stable.
- `RD_LAT`, 2: cycles from the slave read strobe to valid `s_rd_dat`.
- `STARVE_CYC`, 4096: cycles of unserved brake request before `brk_starve` sets.
- `U_DLY`, 1: simulation register delay.

Ports:
- `clk`  in  1  80 MHz system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `h_cs_n`  in  1  host chip select, low for one cycle per access.
- `h_we`  in  1  host write strobe, qualified by `h_cs_n`.
- `h_re`  in  1  host read strobe, qualified by `h_cs_n`.
- `h_addr`  in  8  host register address.
- `h_din`  in  8  host write data.
- `h_dout`  out  8  host read data; equals `s_rd_dat` directly.
- `brk_req`  in  1  brake access request; held high until `brk_ack`.
- `brk_wr`  in  1  1 = write, 0 = read; stable while `brk_req` is high.
- `brk_addr`  in  8  brake register address.
- `brk_wdata`  in  8  brake write data.
- `brk_ack`  out  1  one-cycle completion pulse.
- `brk_rdata`  out  8  read result; valid with `brk_ack` and held until the next read completes.
- `brk_clr`  in  1  clears `brk_starve`.
- `brk_starve`  out  1  sticky starvation flag.
- `s_cs_n`, `s_we`, `s_re`  out  1 each  slave strobes.
- `s_addr`, `s_din`  out  8 each  slave address and write data.
- `s_rd_dat`  in  8  slave read data.

## Operation
Host path:
- When `h_cs_n`=0, the slave port carries the host signals combinationally, in every state. Host always wins.
- Any cycle with `h_cs_n`=0 and (`h_we`|`h_re`) loads the guard counter with `HOST_GUARD`.
- Otherwise the guard counter decrements and saturates at 0.

States and transitions:
- **IDLE**
  - Go to ACC when `brk_req`, `h_cs_n`=1 and guard=0.
  - On that transition, latch `brk_wr`, `brk_addr` and `brk_wdata`.
- **ACC**
  - If `h_cs_n`=1: drive `s_cs_n`=0, `s_we`=wr, `s_re`=~wr and the latched addr/data for exactly one cycle.
    - Write: go to DONE.
    - Read: go to RDW with the wait counter = `RD_LAT`-1.
  - If `h_cs_n`=0: the brake strobe is suppressed and the state stays ACC.
- **RDW**
  - Decrement the wait counter.
  - At 0, capture `s_rd_dat` into `brk_rdata` and go to DONE.
  - A host strobe during RDW aborts the read: go to IDLE with no ack. The request stays pending and retries once the guard clears.
- **DONE**
  - Pulse `brk_ack` for one cycle, then go to IDLE.

Slave port when neither master is active: `s_cs_n`=1, `s_we`=`s_re`=0, addr/din hold their last brake value.

## Timing
- Reset values: `s_cs_n`=1; `s_we`, `s_re`, `s_addr`, `s_din`, `brk_ack`, `brk_rdata`, `brk_starve`=0; state IDLE; guard=0.
- Brake write with no contention: `brk_req` sampled in cycle 0, slave strobe in cycle 1, `brk_ack` in cycle 2.
- Brake read with no contention: strobe in cycle 1, capture in cycle 1+`RD_LAT`, ack in the following cycle. With `RD_LAT`=2, ack is in cycle 4.
- Back-to-back: a request still high in the cycle after `brk_ack` starts a new access.
- Host latency: 0 cycles (combinational mux).
- Reset mid-operation: the FSM returns to IDLE immediately, no ack is issued, and the slave strobes deassert.
- `brk_req` dropped before ack is a protocol violation; the transaction in flight still completes and acks.

## Configuration
- `CAN_ARB_STARVE_EN` defined:
  - A 13-bit saturating counter increments each cycle `brk_req`=1 and `brk_ack`=0, and clears on `brk_ack`.
  - Reaching `STARVE_CYC` sets `brk_starve`.
  - `brk_starve` clears only on `brk_clr`. If `brk_clr` coincides with the set condition, set wins.
- `CAN_ARB_STARVE_EN` undefined: no counter; `brk_starve` is tied to 0 and `brk_clr` is ignored.

## Test plan
- Brake write addr 0x0A, data 0x5C, host idle -> one slave write strobe with `s_addr`=0x0A, `s_din`=0x5C; `brk_ack` 2 cycles after the request.
- Brake read addr 0x02 with `s_rd_dat`=0x3F -> `brk_rdata`=0x3F, `brk_ack` 4 cycles after the request (`RD_LAT`=2).
- Host write in the same cycle the brake reaches ACC -> slave sees only the host access; brake strobe deferred until host is idle and guard is 0 (≥9 cycles later); then exactly one brake strobe and one ack.
- Host read during RDW -> brake read aborted with no ack; `h_dout` shows host data; brake retries after the guard and acks with the correct data.
- `CAN_ARB_STARVE_EN` defined, host strobing every 4 cycles for 5000 cycles with `brk_req` high -> `brk_starve`=1 after 4096 cycles; `brk_clr` pulse -> 0; without the macro, `brk_starve` stays 0.
- Reset asserted during ACC -> all slave strobes inactive, `brk_ack` never pulses; after release, the pending request completes normally.
